// File: rtl/scie_cfir_pkg.sv
// Shared opcodes, FSM states and the complex sample type for the scie_cfir unit.
// cplx_t is sized for the default 16-bit component width.
package scie_cfir_pkg;

  localparam logic [6:0] OP_LOAD  = 7'h0B;
  localparam logic [6:0] OP_PUSH  = 7'h2B;
  localparam logic [6:0] OP_READ  = 7'h5B;
  localparam logic [6:0] OP_CLEAR = 7'h7B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_DRAIN
  } state_t;

  localparam int CPLX_DW = 16;

  typedef struct packed {
    logic signed [CPLX_DW-1:0] re;
    logic signed [CPLX_DW-1:0] im;
  } cplx_t;

endpackage

// File: rtl/scie_cfir_cmac.sv
// One complex multiplier lane of the CFIR MAC pipeline; the full-width
// 2*DW+1 bit product is registered to form the product stage.
module scie_cfir_cmac
  import scie_cfir_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic signed [DW-1:0] i_aRe,
  input  logic signed [DW-1:0] i_aIm,
  input  logic signed [DW-1:0] i_bRe,
  input  logic signed [DW-1:0] i_bIm,
  output logic signed [2*DW:0] o_pRe,
  output logic signed [2*DW:0] o_pIm
);

  logic signed [2*DW-1:0] w_rr;
  logic signed [2*DW-1:0] w_ii;
  logic signed [2*DW-1:0] w_ri;
  logic signed [2*DW-1:0] w_ir;

  assign w_rr = i_aRe * i_bRe;
  assign w_ii = i_aIm * i_bIm;
  assign w_ri = i_aRe * i_bIm;
  assign w_ir = i_aIm * i_bRe;

  // Sign-extend each partial product by one bit so the sum/difference cannot overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      o_pRe <= '0;
      o_pIm <= '0;
    end else begin
      o_pRe <= {w_rr[2*DW-1], w_rr} - {w_ii[2*DW-1], w_ii};
      o_pIm <= {w_ri[2*DW-1], w_ri} + {w_ir[2*DW-1], w_ir};
    end
  end

endmodule

// File: rtl/scie_cfir.sv
// Complex FIR SCIE unit: banked coefficients, shared delay line, time-multiplexed MAC.
// Optional SCIE_CFIR_SAT_EN saturates the output instead of wrapping.
module scie_cfir
  import scie_cfir_pkg::*;
#(
  parameter int TAPS  = 5,
  parameter int LANES = 1,
  parameter int DW    = 16,
  parameter int BANKS = 2,
  parameter int SHIFT = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_valid,
  input  logic [31:0]          io_insn,
  input  logic signed [DW-1:0] io_rs1_real,
  input  logic signed [DW-1:0] io_rs1_imag,
  input  logic [31:0]          io_rs2,
  output logic                 io_ready,
  output logic signed [DW-1:0] io_rd_real,
  output logic signed [DW-1:0] io_rd_imag,
  output logic                 io_overrun
);

  localparam int G   = (TAPS + LANES - 1) / LANES;
  localparam int PW  = 2*DW + 1;
  localparam int AW  = 2*DW + $clog2(TAPS) + 1;
  localparam int TIW = (TAPS  > 1) ? $clog2(TAPS)  : 1;
  localparam int BW  = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int GW  = (G     > 1) ? $clog2(G)     : 1;

  logic signed [DW-1:0] r_coefRe [BANKS][TAPS];
  logic signed [DW-1:0] r_coefIm [BANKS][TAPS];
  logic signed [DW-1:0] r_xRe [TAPS];
  logic signed [DW-1:0] r_xIm [TAPS];

  state_t               r_state;
  logic [GW-1:0]        r_grp;
  logic                 r_drain;
  logic [BW-1:0]        r_bank;
  logic                 r_bankOk;
  logic                 r_pValid;
  logic                 r_ready;
  logic                 r_overrun;
  logic signed [AW-1:0] r_accRe;
  logic signed [AW-1:0] r_accIm;
  logic signed [DW-1:0] r_resRe;
  logic signed [DW-1:0] r_resIm;
  logic signed [DW-1:0] r_rdRe;
  logic signed [DW-1:0] r_rdIm;

  logic [6:0]     w_op;
  logic [1:0]     w_bankRaw;
  logic [BW-1:0]  w_bank;
  logic [TIW-1:0] w_tap;
  logic           w_bankOk;
  logic           w_inRange;
  logic           w_isLoad;
  logic           w_isPush;
  logic           w_isClear;
  logic           w_doLoad;
  logic           w_doPush;
  logic           w_doClear;
  logic           w_doRead;
  logic           w_drop;

  assign w_op      = io_insn[6:0];
  assign w_bankRaw = io_insn[13:12];
  assign w_bank    = w_bankRaw[BW-1:0];
  assign w_tap     = io_rs2[TIW-1:0];
  assign w_bankOk  = 32'(w_bankRaw) < 32'(BANKS);
  assign w_inRange = (io_rs2 < 32'(TAPS)) && w_bankOk;

  assign w_isLoad  = io_valid && (w_op == OP_LOAD);
  assign w_isPush  = io_valid && (w_op == OP_PUSH);
  assign w_isClear = io_valid && (w_op == OP_CLEAR);
  assign w_doRead  = io_valid && (w_op == OP_READ);
  assign w_doLoad  = w_isLoad && r_ready && w_inRange;
  assign w_doPush  = w_isPush && r_ready;
  assign w_doClear = w_isClear && r_ready;
  assign w_drop    = (w_isLoad || w_isPush || w_isClear) && !r_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < BANKS; b++) begin
        for (int t = 0; t < TAPS; t++) begin
          r_coefRe[b][t] <= '0;
          r_coefIm[b][t] <= '0;
        end
      end
    end else if (w_doLoad) begin
      r_coefRe[w_bank][w_tap] <= io_rs1_real;
      r_coefIm[w_bank][w_tap] <= io_rs1_imag;
    end
  end

  // The delay line is shared by every bank; only PUSH and CLEAR touch it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int t = 0; t < TAPS; t++) begin
        r_xRe[t] <= '0;
        r_xIm[t] <= '0;
      end
    end else if (w_doClear) begin
      for (int t = 0; t < TAPS; t++) begin
        r_xRe[t] <= '0;
        r_xIm[t] <= '0;
      end
    end else if (w_doPush) begin
      r_xRe[0] <= io_rs1_real;
      r_xIm[0] <= io_rs1_imag;
      for (int t = 1; t < TAPS; t++) begin
        r_xRe[t] <= r_xRe[t-1];
        r_xIm[t] <= r_xIm[t-1];
      end
    end
  end

  logic signed [DW-1:0] w_cRe [LANES];
  logic signed [DW-1:0] w_cIm [LANES];
  logic signed [DW-1:0] w_sRe [LANES];
  logic signed [DW-1:0] w_sIm [LANES];
  logic signed [PW-1:0] w_pRe [LANES];
  logic signed [PW-1:0] w_pIm [LANES];

  // Lanes past the last tap in the final group see zero operands.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_cRe[l] = '0;
      w_cIm[l] = '0;
      w_sRe[l] = '0;
      w_sIm[l] = '0;
      if ((int'(r_grp) * LANES + l) < TAPS) begin
        w_sRe[l] = r_xRe[TIW'(int'(r_grp) * LANES + l)];
        w_sIm[l] = r_xIm[TIW'(int'(r_grp) * LANES + l)];
        if (r_bankOk) begin
          w_cRe[l] = r_coefRe[r_bank][TIW'(int'(r_grp) * LANES + l)];
          w_cIm[l] = r_coefIm[r_bank][TIW'(int'(r_grp) * LANES + l)];
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    scie_cfir_cmac #(.DW(DW)) u_cmac (
      .clock (clock),
      .reset (reset),
      .i_aRe (w_cRe[l]),
      .i_aIm (w_cIm[l]),
      .i_bRe (w_sRe[l]),
      .i_bIm (w_sIm[l]),
      .o_pRe (w_pRe[l]),
      .o_pIm (w_pIm[l])
    );
  end

  logic signed [AW-1:0] w_sumRe;
  logic signed [AW-1:0] w_sumIm;

  always_comb begin
    w_sumRe = '0;
    w_sumIm = '0;
    for (int l = 0; l < LANES; l++) begin
      w_sumRe = w_sumRe + AW'(w_pRe[l]);
      w_sumIm = w_sumIm + AW'(w_pIm[l]);
    end
  end

  logic signed [AW-1:0] w_shRe;
  logic signed [AW-1:0] w_shIm;
  logic signed [DW-1:0] w_outRe;
  logic signed [DW-1:0] w_outIm;
  logic signed [DW-1:0] w_rbRe;
  logic signed [DW-1:0] w_rbIm;

  assign w_shRe = r_accRe >>> SHIFT;
  assign w_shIm = r_accIm >>> SHIFT;
  assign w_rbRe = w_inRange ? r_coefRe[w_bank][w_tap] : '0;
  assign w_rbIm = w_inRange ? r_coefIm[w_bank][w_tap] : '0;

`ifdef SCIE_CFIR_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  assign w_outRe = (w_shRe > SAT_MAX) ? SAT_MAX[DW-1:0] :
                   (w_shRe < SAT_MIN) ? SAT_MIN[DW-1:0] : w_shRe[DW-1:0];
  assign w_outIm = (w_shIm > SAT_MAX) ? SAT_MAX[DW-1:0] :
                   (w_shIm < SAT_MIN) ? SAT_MIN[DW-1:0] : w_shIm[DW-1:0];
`else
  assign w_outRe = w_shRe[DW-1:0];
  assign w_outIm = w_shIm[DW-1:0];
`endif

  logic w_unused;
  assign w_unused = ^{io_insn[31:15], io_insn[11:7], w_shRe, w_shIm};

  // Completion is written after READ so it wins when both land on one edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_grp     <= '0;
      r_drain   <= 1'b0;
      r_bank    <= '0;
      r_bankOk  <= 1'b0;
      r_pValid  <= 1'b0;
      r_ready   <= 1'b1;
      r_overrun <= 1'b0;
      r_accRe   <= '0;
      r_accIm   <= '0;
      r_resRe   <= '0;
      r_resIm   <= '0;
      r_rdRe    <= '0;
      r_rdIm    <= '0;
    end else begin
      r_pValid <= (r_state == ST_MAC);
      if (r_pValid) begin
        r_accRe <= r_accRe + w_sumRe;
        r_accIm <= r_accIm + w_sumIm;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
      if (w_doRead) begin
        r_rdRe <= io_insn[14] ? w_rbRe : r_resRe;
        r_rdIm <= io_insn[14] ? w_rbIm : r_resIm;
      end
      if (w_doClear) begin
        r_resRe <= '0;
        r_resIm <= '0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_doPush) begin
            r_state  <= ST_MAC;
            r_grp    <= '0;
            r_bank   <= w_bank;
            r_bankOk <= w_bankOk;
            r_ready  <= 1'b0;
            r_accRe  <= '0;
            r_accIm  <= '0;
          end
        end
        ST_MAC: begin
          r_grp <= r_grp + GW'(1);
          if (r_grp == GW'(G-1)) begin
            r_state <= ST_DRAIN;
            r_drain <= 1'b0;
          end
        end
        ST_DRAIN: begin
          r_drain <= 1'b1;
          if (r_drain) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_resRe <= w_outRe;
            r_resIm <= w_outIm;
            r_rdRe  <= w_outRe;
            r_rdIm  <= w_outIm;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_ready   = r_ready;
  assign io_rd_real = r_rdRe;
  assign io_rd_imag = r_rdIm;
  assign io_overrun = r_overrun;

endmodule

// File: tb/tb_scie_cfir.sv
// Scoreboard bench for scie_cfir with default parameters; expected results are
// queued with their due cycle and matched by a separate output monitor.
module tb_scie_cfir;
  import scie_cfir_pkg::*;

  localparam int LAT = 7;
`ifdef SCIE_CFIR_SAT_EN
  localparam int SAT_EXP = 32767;
`else
  localparam int SAT_EXP = 1;
`endif

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               io_valid;
  logic [31:0]        io_insn;
  logic signed [15:0] io_rs1_real;
  logic signed [15:0] io_rs1_imag;
  logic [31:0]        io_rs2;
  logic               io_ready;
  logic signed [15:0] io_rd_real;
  logic signed [15:0] io_rd_imag;
  logic               io_overrun;

  scie_cfir dut (
    .clock       (clock),
    .reset       (reset),
    .io_valid    (io_valid),
    .io_insn     (io_insn),
    .io_rs1_real (io_rs1_real),
    .io_rs1_imag (io_rs1_imag),
    .io_rs2      (io_rs2),
    .io_ready    (io_ready),
    .io_rd_real  (io_rd_real),
    .io_rd_imag  (io_rd_imag),
    .io_overrun  (io_overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    cplx_t val;
    int    due;
    int    id;
  } exp_t;

  exp_t sbQ[$];
  int   total  = 0;
  int   bad    = 0;
  int   cycle  = 0;
  int   nextId = 0;

  int cRe[5] = '{30, -29, -19, -22, -21};
  int cIm[5] = '{-49, -2, -1, -17, 35};

  always @(posedge clock) cycle++;

  task automatic checkOutput(input string name, input int id, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s #%0d: got %0d, want %0d", name, id, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input int bank, input logic sel,
                               input int re, input int im, input int idx);
    io_valid    = 1'b1;
    io_insn     = {17'd0, sel, 2'(bank), 5'd0, op};
    io_rs1_real = 16'(re);
    io_rs1_imag = 16'(im);
    io_rs2      = 32'(idx);
    @(negedge clock);
    io_valid = 1'b0;
    io_insn  = '0;
  endtask

  task automatic expectAt(input int due, input int expRe, input int expIm);
    exp_t e;
    e.val.re = 16'(expRe);
    e.val.im = 16'(expIm);
    e.due    = due;
    e.id     = nextId++;
    sbQ.push_back(e);
  endtask

  task automatic doPush(input int bank, input int re, input int im, input int expRe, input int expIm);
    expectAt(cycle + 1 + LAT, expRe, expIm);
    applyStimulus(OP_PUSH, bank, 1'b0, re, im, 0);
  endtask

  task automatic doRead(input int bank, input logic sel, input int idx, input int expRe, input int expIm);
    expectAt(cycle + 1, expRe, expIm);
    applyStimulus(OP_READ, bank, sel, 0, 0, idx);
  endtask

  task automatic waitReady(input string name);
    for (int i = 0; i < 30 && !io_ready; i++) @(negedge clock);
    if (!io_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: io_ready still %0d after 30 cycles, want 1", name, io_ready);
    end
  endtask

  // Output monitor: an output event is a READ accepted on the last edge or a rising io_ready.
  initial begin : monitor
    logic lastReady;
    logic sawRead;
    int   hit;
    lastReady = 1'b1;
    forever begin
      @(posedge clock);
      sawRead = io_valid && (io_insn[6:0] == OP_READ);
      @(negedge clock);
      if (!reset) begin
        lastReady = io_ready;
      end else begin
        if (sawRead || (io_ready && !lastReady)) begin
          hit = -1;
          foreach (sbQ[i]) if (hit < 0 && sbQ[i].due == cycle) hit = i;
          if (hit < 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_output: got (%0d,%0d) at cycle %0d, want no output",
                     io_rd_real, io_rd_imag, cycle);
          end else begin
            checkOutput("rd_real", sbQ[hit].id, int'(io_rd_real), int'(sbQ[hit].val.re));
            checkOutput("rd_imag", sbQ[hit].id, int'(io_rd_imag), int'(sbQ[hit].val.im));
            sbQ.delete(hit);
          end
        end
        for (int i = sbQ.size() - 1; i >= 0; i--) begin
          if (sbQ[i].due < cycle) begin
            total++;
            bad++;
            $display("[TB] FAIL missing_output #%0d: got no output by cycle %0d, want one at cycle %0d",
                     sbQ[i].id, cycle, sbQ[i].due);
            sbQ.delete(i);
          end
        end
        lastReady = io_ready;
      end
    end
  end

  initial begin : stimulus
    io_valid    = 1'b0;
    io_insn     = '0;
    io_rs1_real = '0;
    io_rs1_imag = '0;
    io_rs2      = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset_ready",   0, int'(io_ready),   1);
    checkOutput("reset_rd_real", 0, int'(io_rd_real), 0);
    checkOutput("reset_rd_imag", 0, int'(io_rd_imag), 0);
    checkOutput("reset_overrun", 0, int'(io_overrun), 0);
    #2 reset = 1'b1;
    @(negedge clock);

    for (int k = 0; k < 5; k++) applyStimulus(OP_LOAD, 0, 1'b0, cRe[k], cIm[k], k);
    doPush(0, 33, -36, -774, -2697);
    waitReady("push1");
    doPush(0, 4, -4, -1105, 662);
    waitReady("push2");

    doPush(0, 34, -33, -1384, -1897);
    checkOutput("busy_ready", 0, int'(io_ready), 0);
    applyStimulus(OP_PUSH, 0, 1'b0, 100, 100, 0);
    checkOutput("overrun_set", 0, int'(io_overrun), 1);
    doRead(0, 1'b0, 0, -1105, 662);
    waitReady("push3");
    checkOutput("overrun_sticky", 0, int'(io_overrun), 1);

    applyStimulus(OP_LOAD, 0, 1'b0, 32767, 0, 0);
    for (int k = 1; k < 5; k++) applyStimulus(OP_LOAD, 0, 1'b0, 0, 0, k);
    doPush(0, 32767, 0, SAT_EXP, 0);
    waitReady("push_sat");

    applyStimulus(OP_LOAD, 1, 1'b0, 1, 0, 0);
    applyStimulus(OP_LOAD, 2, 1'b0, 777, 777, 0);
    applyStimulus(OP_CLEAR, 0, 1'b0, 0, 0, 0);
    doRead(0, 1'b0, 0, 0, 0);
    doPush(1, 5, 7, 5, 7);
    waitReady("push_bank1");
    doRead(0, 1'b1, 0, 32767, 0);
    doRead(1, 1'b1, 5, 0, 0);
    doRead(2, 1'b1, 0, 0, 0);
    doRead(1, 1'b1, 0, 1, 0);

    applyStimulus(OP_PUSH, 0, 1'b0, 3, 3, 0);
    repeat (2) @(negedge clock);
    checkOutput("busy_before_reset", 0, int'(io_ready), 0);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort_ready",   0, int'(io_ready),   1);
    checkOutput("abort_rd_real", 0, int'(io_rd_real), 0);
    checkOutput("abort_rd_imag", 0, int'(io_rd_imag), 0);
    checkOutput("abort_overrun", 0, int'(io_overrun), 0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    doPush(0, 9, 9, 0, 0);
    waitReady("push_after_reset");

    for (int i = 0; i < 20 && sbQ.size() != 0; i++) @(negedge clock);
    if (sbQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, want 0", sbQ.size());
    end
    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
